// File: rtl/mem_test_seq_if.sv
// Memory/pattern bus between the test sequencer and its memory + pattern mux.
//   master (sequencer): drives sel_o, mem_we_o, mem_addr_o, mem_wdata_o;
//                       receives pattern_i, mem_rdata_i.
//   slave  (memory/mux): the reverse.
interface mem_test_seq_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [2:0]            sel_o;
  logic [DATA_WIDTH-1:0] pattern_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    output sel_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  pattern_i, mem_rdata_i
  );

  modport slave (
    input  sel_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output pattern_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_test_seq.sv
// Memory test sequencer: for each of 8 mux patterns, writes pattern^addr to
// every word, reads it back and compares, then reports error statistics.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             one-cycle run request (honoured in IDLE/DONE only)
//   bus (master)        pattern select, pattern in, memory write/read bus
//   busy_o, done_o      run in progress / run complete (held)
//   pass_o              done with zero miscompares
//   err_count_o         saturating miscompare count
//   first_err_*_o       address/sel of first miscompare, plus valid flag
module mem_test_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  mem_test_seq_if.master        bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [2:0]            first_err_sel_o,
  output logic                  first_err_valid_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [2:0]            LAST_SEL  = 3'd7;
  localparam logic [15:0]           ERR_MAX   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_WIDTH-1:0] ferr_addr_q, ferr_addr_d;
  logic [2:0]            ferr_sel_q, ferr_sel_d;
  logic                  ferr_valid_q, ferr_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  miscompare;

  // Read data belongs to the address registered last cycle; sel is stable
  // across the whole pass, so pattern_i is still the right reference.
  assign miscompare = rd_valid_q &&
                      (bus.mem_rdata_i != (bus.pattern_i ^ DATA_WIDTH'(rd_addr_q)));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      addr_q       <= '0;
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      err_q        <= '0;
      ferr_addr_q  <= '0;
      ferr_sel_q   <= '0;
      ferr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_addr_q    <= rd_addr_d;
      err_q        <= err_d;
      ferr_addr_q  <= ferr_addr_d;
      ferr_sel_q   <= ferr_sel_d;
      ferr_valid_q <= ferr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // Next-state, compare and status logic
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    rd_valid_d   = 1'b0;
    rd_addr_d    = addr_q;
    err_d        = err_q;
    ferr_addr_d  = ferr_addr_q;
    ferr_sel_d   = ferr_sel_q;
    ferr_valid_d = ferr_valid_q;

    if (miscompare) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + 16'd1;
      end
      if (!ferr_valid_q) begin
        ferr_addr_d  = rd_addr_q;
        ferr_sel_d   = sel_q;
        ferr_valid_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d      = S_WRITE;
          sel_d        = '0;
          addr_d       = '0;
          err_d        = '0;
          ferr_addr_d  = '0;
          ferr_sel_d   = '0;
          ferr_valid_d = 1'b0;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (addr_q == LAST_ADDR) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_valid_d = 1'b1;
        addr_d     = addr_q + ADDR_WIDTH'(1);
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sel_q == LAST_SEL) begin
          state_d = S_DONE;
        end else begin
          sel_d   = sel_q + 3'd1;
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == 16'd0);
  end

  // Memory bus is decoded from registered state so it follows the current
  // pattern_i, which the mux returns combinationally for sel_o.
  assign bus.sel_o       = sel_q;
  assign bus.mem_we_o    = (state_q == S_WRITE);
  assign bus.mem_addr_o  = ((state_q == S_WRITE) || (state_q == S_READ)) ? addr_q : '0;
  assign bus.mem_wdata_o = (state_q == S_WRITE) ?
                           (bus.pattern_i ^ DATA_WIDTH'(addr_q)) : '0;

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_count_o       = err_q;
  assign first_err_addr_o  = ferr_addr_q;
  assign first_err_sel_o   = ferr_sel_q;
  assign first_err_valid_o = ferr_valid_q;

endmodule

// File: tb/tb_mem_test_seq.sv
// Bench for mem_test_seq with an 8-entry pattern mux and a 1-cycle-read RAM
// that can inject read faults.
module tb_mem_test_seq;

  localparam int unsigned DW         = 32;
  localparam int unsigned AW         = 2;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned RUN_CYCLES = 72;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, pass, fvalid;
  logic [15:0]   err_count;
  logic [AW-1:0] faddr;
  logic [2:0]    fsel;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_test_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_test_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .bus              (bus),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_count),
    .first_err_addr_o (faddr),
    .first_err_sel_o  (fsel),
    .first_err_valid_o(fvalid)
  );

  // Pattern mux
  logic [DW-1:0] pats [8] = '{32'h00000000, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555,
                              32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'h87654321};
  assign bus.pattern_i = pats[bus.sel_o];

  // RAM with registered read and fault injection on the returned data
  // fault: 0 none, 1 bit0 stuck-0 @addr1, 2 always 0xDEADBEEF, 3 bit0 stuck-0 @addr2
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] rd_addr_q;
  int            fault_mode = 0;

  always @(posedge clk) begin
    if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
    rd_q      <= ram[bus.mem_addr_o];
    rd_addr_q <= bus.mem_addr_o;
  end

  always_comb begin
    bus.mem_rdata_i = rd_q;
    if (fault_mode == 1 && rd_addr_q == 2'd1) bus.mem_rdata_i = rd_q & ~32'h1;
    if (fault_mode == 3 && rd_addr_q == 2'd2) bus.mem_rdata_i = rd_q & ~32'h1;
    if (fault_mode == 2)                      bus.mem_rdata_i = 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Write scoreboard: expected writes pushed at start, popped as the DUT writes
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic push_run_writes();
    wr_t e;
    exp_q.delete();
    for (int s = 0; s < 8; s++) begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        e.addr = AW'(a);
        e.data = pats[s] ^ DW'(a);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.mem_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(bus.mem_addr_o), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr_o), 32'(mon_e.addr));
        check("wr_data", bus.mem_wdata_o, mon_e.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},    32'(bus.sel_o),       32'd0);
    check({tag, "_we"},     32'(bus.mem_we_o),    32'd0);
    check({tag, "_addr"},   32'(bus.mem_addr_o),  32'd0);
    check({tag, "_wdata"},  bus.mem_wdata_o,      32'd0);
    check({tag, "_busy"},   32'(busy),            32'd0);
    check({tag, "_done"},   32'(done),            32'd0);
    check({tag, "_pass"},   32'(pass),            32'd0);
    check({tag, "_err"},    32'(err_count),       32'd0);
    check({tag, "_faddr"},  32'(faddr),           32'd0);
    check({tag, "_fsel"},   32'(fsel),            32'd0);
    check({tag, "_fvalid"}, 32'(fvalid),          32'd0);
  endtask

  typedef struct {
    int            fault;
    int            start_at;   // busy-cycle index to pulse start_i, -1 = none
    logic [15:0]   errs;
    logic          pass;
    logic          fvalid;
    logic [AW-1:0] faddr;
    logic [2:0]    fsel;
  } vec_t;

  // Runs a full test from IDLE/DONE and checks the final status.
  task automatic run_vec(input vec_t v);
    int cyc;
    fault_mode = v.fault;
    push_run_writes();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("start_busy",   32'(busy),      32'd1);
    check("start_done",   32'(done),      32'd0);
    check("start_err",    32'(err_count), 32'd0);
    check("start_fvalid", 32'(fvalid),    32'd0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      start = (cyc == v.start_at);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 32'(cyc),       32'(RUN_CYCLES));
    check("done",        32'(done),      32'd1);
    check("pass",        32'(pass),      32'(v.pass));
    check("err_count",   32'(err_count), 32'(v.errs));
    check("fvalid",      32'(fvalid),    32'(v.fvalid));
    if (v.fvalid) begin
      check("faddr", 32'(faddr), 32'(v.faddr));
      check("fsel",  32'(fsel),  32'(v.fsel));
    end
    check("writes_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("done_held", 32'(done), 32'd1);
  endtask

  vec_t vecs [6];
  vec_t clean;

  initial begin
    int cyc;
    // Stuck-at-0 on bit 0: data written is pattern^addr, so addr1 flips
    // pattern bit0 (fails for even patterns: sel 0,2,5,6) and addr2 keeps it
    // (fails for odd patterns: sel 1,3,4,7).
    vecs[0] = '{fault: 0, start_at: -1, errs: 16'd0,  pass: 1'b1, fvalid: 1'b0, faddr: 2'd0, fsel: 3'd0};
    vecs[1] = '{fault: 1, start_at: -1, errs: 16'd4,  pass: 1'b0, fvalid: 1'b1, faddr: 2'd1, fsel: 3'd0};
    vecs[2] = '{fault: 2, start_at: -1, errs: 16'd32, pass: 1'b0, fvalid: 1'b1, faddr: 2'd0, fsel: 3'd0};
    vecs[3] = '{fault: 3, start_at: -1, errs: 16'd4,  pass: 1'b0, fvalid: 1'b1, faddr: 2'd2, fsel: 3'd1};
    // start_i during READ of sel 3 (busy cycles 31..34) is ignored
    vecs[4] = '{fault: 0, start_at: 32, errs: 16'd0,  pass: 1'b1, fvalid: 1'b0, faddr: 2'd0, fsel: 3'd0};
    vecs[5] = '{fault: 2, start_at: 5,  errs: 16'd32, pass: 1'b0, fvalid: 1'b1, faddr: 2'd0, fsel: 3'd0};
    clean   = vecs[0];

    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_wait_busy", 32'(busy), 32'd0);
    check("idle_wait_done", 32'(done), 32'd0);

    // Back-to-back runs also exercise restart from DONE clearing counters
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset during WRITE of sel 5 (busy cycles 45..48), checked before any edge
    fault_mode = 0;
    push_run_writes();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 46) begin
      cyc++;
      @(negedge clk);
    end
    check("pre_rst_sel", 32'(bus.sel_o), 32'd5);
    check("pre_rst_we",  32'(bus.mem_we_o), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    run_vec(clean);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
